rf_wr_arbiter: RTL

RF_WR_ARBITER -- requirements
Module: rf_wr_arbiter

---
 rtl/rf_wr_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/rf_wr_arbiter.sv
// Two-requester write arbiter for a register file with a zero-fill scrub sweep.
// Define RF_BYPASS_EN to forward the in-flight write data onto matching read ports.
module rf_wr_arbiter #(
    parameter int DW = 16,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          Clear,

    input  logic          w0_valid,
    input  logic [AW-1:0] w0_addr,
    input  logic [DW-1:0] w0_data,
    output logic          w0_ready,

    input  logic          w1_valid,
    input  logic [AW-1:0] w1_addr,
    input  logic [DW-1:0] w1_data,
    output logic          w1_ready,

    input  logic          scrub_req,
    output logic          scrub_busy,
    output logic          scrub_done,

    input  logic [AW-1:0] rd_a_addr,
    input  logic [AW-1:0] rd_b_addr,
    output logic [DW-1:0] rd_a_data,
    output logic [DW-1:0] rd_b_data,

    output logic [AW-1:0] Aaddr,
    output logic [AW-1:0] Baddr,
    input  logic [DW-1:0] A,
    input  logic [DW-1:0] B,

    output logic [AW-1:0] Caddr,
    output logic [DW-1:0] C,
    output logic          Load
);

    // state | meaning
    // RUN   | arbitrate requester writes onto the register-file write port
    // SCRUB | zero-fill every register, one per cycle, requesters stalled
    typedef enum logic {
        RUN   = 1'b0,
        SCRUB = 1'b1
    } state_t;

    localparam logic [AW-1:0] CNT_LAST = '1;

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] cnt;
    logic          cnt_last;
    logic          last_grant;
    logic          accept;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_data;

    assign cnt_last = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge Clear) begin
        if (!Clear) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (scrub_req) begin
                    state_next = SCRUB;
                end
            end
            SCRUB: begin
                if (cnt_last) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    // last_grant=1 means requester 1 won last, so requester 0 wins a tie
    always_comb begin
        w0_ready   = 1'b0;
        w1_ready   = 1'b0;
        scrub_busy = 1'b0;
        case (state)
            RUN: begin
                if (!scrub_req) begin
                    if (w0_valid && (!w1_valid || last_grant)) begin
                        w0_ready = 1'b1;
                    end else if (w1_valid) begin
                        w1_ready = 1'b1;
                    end
                end
            end
            SCRUB: begin
                scrub_busy = 1'b1;
            end
            default: begin
                scrub_busy = 1'b0;
            end
        endcase
    end

    assign accept   = w0_ready | w1_ready;
    assign win_addr = w1_ready ? w1_addr : w0_addr;
    assign win_data = w1_ready ? w1_data : w0_data;

    // During SCRUB, cnt always equals the address currently presented on Caddr
    always_ff @(posedge clk or negedge Clear) begin
        if (!Clear) begin
            Load       <= 1'b0;
            Caddr      <= '0;
            C          <= '0;
            cnt        <= '0;
            scrub_done <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            scrub_done <= (state == SCRUB) && cnt_last;
            if (accept) begin
                last_grant <= w1_ready;
            end
            case (state)
                RUN: begin
                    if (scrub_req) begin
                        cnt   <= '0;
                        Load  <= 1'b1;
                        Caddr <= '0;
                        C     <= '0;
                    end else if (accept) begin
                        Load  <= (win_addr != '0);
                        Caddr <= win_addr;
                        C     <= win_data;
                    end else begin
                        Load  <= 1'b0;
                    end
                end
                SCRUB: begin
                    C <= '0;
                    if (cnt_last) begin
                        cnt  <= '0;
                        Load <= 1'b0;
                    end else begin
                        cnt   <= cnt + 1'b1;
                        Caddr <= cnt + 1'b1;
                        Load  <= 1'b1;
                    end
                end
                default: begin
                    Load <= 1'b0;
                end
            endcase
        end
    end

    assign Aaddr = rd_a_addr;
    assign Baddr = rd_b_addr;

`ifdef RF_BYPASS_EN
    assign rd_a_data = (Load && (Caddr == rd_a_addr)) ? C : A;
    assign rd_b_data = (Load && (Caddr == rd_b_addr)) ? C : B;
`else
    assign rd_a_data = A;
    assign rd_b_data = B;
`endif

endmodule
